// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  // Operation codes presented by the EX stage.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  // Controller states: MUL waits out the multiply latency, DIV iterates,
  // FIX applies the sign correction and writes HI/LO.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // Quotient bits produced by the divider, one per DIV-state cycle.
  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step, MSB first.
module div_core (
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  // quo_reg starts as the dividend; its MSB is shifted into the partial
  // remainder each step while the new quotient bit enters at the bottom.
  logic [31:0] rem_reg, rem_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] dvs_reg, dvs_next;
  logic [32:0] shifted;
  logic        ge;

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
    end else begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      dvs_reg <= dvs_next;
    end
  end

  // One restoring step: 33-bit partial remainder compared with the divisor.
  // The subtraction result is always below the divisor, so 32 bits suffice.
  always_comb begin
    rem_next = rem_reg;
    quo_next = quo_reg;
    dvs_next = dvs_reg;
    shifted  = {rem_reg, quo_reg[31]};
    ge       = (shifted >= {1'b0, dvs_reg});
    if (load) begin
      rem_next = '0;
      quo_next = dividend;
      dvs_next = divisor;
    end else if (step) begin
      rem_next = ge ? (shifted[31:0] - dvs_reg) : shifted[31:0];
      quo_next = {quo_reg[30:0], ge};
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO and driving the stall request.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        hilo_rd_i,
  output logic        busy_o,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_op_t     op;
  mdu_state_t  state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [63:0] prod_reg, prod_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        div_load, div_step;
  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] quo_mag, rem_mag;
  logic        mul_signed, div_signed;
  logic [63:0] ext_a, ext_b;

  assign op         = mdu_op_t'(op_i);
  assign mul_signed = (op == MDU_MULT);
  assign div_signed = (op == MDU_DIV);
  // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU.
  assign ext_a      = {{32{mul_signed & a_i[31]}}, a_i};
  assign ext_b      = {{32{mul_signed & b_i[31]}}, b_i};
  assign dvd_mag    = (div_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign dvs_mag    = (div_signed && b_i[31]) ? (32'd0 - b_i) : b_i;

  div_core u_div_core (
    .clk       (clk_i),
    .srst      (rst_i),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

  // State, counter, held product, sign flags and HI/LO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      prod_reg  <= prod_next;
      q_neg_reg <= q_neg_next;
      r_neg_reg <= r_neg_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Acceptance, sequencing and result write-back.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    prod_next  = prod_reg;
    q_neg_next = q_neg_reg;
    r_neg_next = r_neg_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              prod_next  = ext_a * ext_b;
              cnt_next   = 5'(MUL_CYCLES - 1);
              state_next = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              div_load   = 1'b1;
              // A zero divisor leaves the all-ones quotient un-negated.
              q_neg_next = div_signed && (a_i[31] ^ b_i[31]) && (b_i != 32'd0);
              r_neg_next = div_signed && a_i[31];
              cnt_next   = 5'(DIV_ITERS - 1);
              state_next = ST_DIV;
            end
            MDU_MTHI: hi_next = a_i;
            MDU_MTLO: lo_next = a_i;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_reg == 5'd0) begin
          {hi_next, lo_next} = prod_reg;
          state_next         = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_reg == 5'd0) begin
          state_next = ST_FIX;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      ST_FIX: begin
        lo_next    = q_neg_reg ? (32'd0 - quo_mag) : quo_mag;
        hi_next    = r_neg_reg ? (32'd0 - rem_mag) : rem_mag;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_reg != ST_IDLE);
  assign stall_req_o = busy_o && (start_i || hilo_rd_i);
  assign hi_o        = hi_reg;
  assign lo_o        = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        hilo_rd_i = 1'b0;
  logic        busy_o, stall_req_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mult_div_unit #(.MUL_CYCLES(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .hilo_rd_i   (hilo_rd_i),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Counts sampled cycles with busy high; bounded so a stuck DUT still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic report(input string tag, input int n);
    $display("%s: busy_cycles=%0d hi=%h lo=%h", tag, n, hi_o, lo_o);
  endtask

  initial begin
    int n;
    int stalls;

    // Reset state
    repeat (2) tick();
    rst_i = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);

    // MULT -3 * 5
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_hold_lo", lo_o, 32'd0);
    wait_idle(n);
    report("MULT -3*5", n);
    check("mult_cycles", 32'(n), 32'd4);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hold_hi", hi_o, 32'hFFFF_FFFF);
    wait_idle(n);
    report("MULTU ffffffff*2", n);
    check("multu_cycles", 32'(n), 32'd4);
    check("multu_hi", hi_o, 32'd1);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);

    // DIVU 100 / 7
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    report("DIVU 100/7", n);
    check("divu_cycles", 32'(n), 32'd33);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);

    // DIV -7 / 2
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    report("DIV -7/2", n);
    check("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    check("div_neg_hi", hi_o, 32'hFFFF_FFFF);

    // DIV overflow 0x80000000 / -1
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    report("DIV ovf", n);
    check("div_ovf_lo", lo_o, 32'h8000_0000);
    check("div_ovf_hi", hi_o, 32'd0);

    // DIV 5 / 0
    issue(MDU_DIV, 32'd5, 32'd0);
    wait_idle(n);
    report("DIV 5/0", n);
    check("div0_cycles", 32'(n), 32'd33);
    check("div0_lo", lo_o, 32'hFFFF_FFFF);
    check("div0_hi", hi_o, 32'd5);

    // MTHI in IDLE
    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
    $display("MTHI: busy=%0b hi=%h lo=%h", busy_o, hi_o, lo_o);
    check("mthi_busy", {31'd0, busy_o}, 32'd0);
    check("mthi_hi", hi_o, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo_o, 32'hFFFF_FFFF);

    // DIVU with a following MFHI held in EX
    issue(MDU_DIVU, 32'd1000, 32'd3);
    hilo_rd_i = 1'b1;
    stalls = 0;
    while (stall_req_o === 1'b1 && stalls < 200) begin
      stalls++;
      tick();
    end
    $display("DIVU 1000/3 with MFHI: stall_cycles=%0d hi=%h lo=%h", stalls, hi_o, lo_o);
    check("mfhi_stall_cycles", 32'(stalls), 32'd33);
    check("mfhi_busy_after", {31'd0, busy_o}, 32'd0);
    check("mfhi_hi", hi_o, 32'd1);
    check("mfhi_lo", lo_o, 32'd333);
    hilo_rd_i = 1'b0;

    // Flushed requests are ignored
    flush_i = 1'b1;
    issue(MDU_MULT, 32'd3, 32'd3);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    issue(MDU_MTLO, 32'h1234_5678, 32'd0);
    $display("flush: busy=%0b hi=%h lo=%h", busy_o, hi_o, lo_o);
    check("flush_lo_kept", lo_o, 32'd333);
    flush_i = 1'b0;

    // MULT held with start_i while a DIV is busy
    issue(MDU_DIV, 32'd20, 32'd3);
    op_i    = MDU_MULT;
    a_i     = 32'd7;
    b_i     = 32'd6;
    start_i = 1'b1;
    stalls  = 0;
    while (busy_o === 1'b1 && stalls < 200) begin
      if (stall_req_o === 1'b1) stalls++;
      tick();
    end
    $display("DIV 20/3 with MULT waiting: stall_cycles=%0d hi=%h lo=%h", stalls, hi_o, lo_o);
    check("held_stall_cycles", 32'(stalls), 32'd33);
    check("held_stall_idle", {31'd0, stall_req_o}, 32'd0);
    check("held_div_lo", lo_o, 32'd6);
    check("held_div_hi", hi_o, 32'd2);
    tick();
    start_i = 1'b0;
    wait_idle(n);
    report("MULT 7*6 after wait", n);
    check("held_mult_cycles", 32'(n), 32'd4);
    check("held_mult_lo", lo_o, 32'd42);
    check("held_mult_hi", hi_o, 32'd0);
    tick();
    check("no_double_issue", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of a divide
    issue(MDU_DIVU, 32'd50, 32'd7);
    repeat (9) tick();
    hilo_rd_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    $display("reset mid-DIV: busy=%0b stall=%0b hi=%h lo=%h", busy_o, stall_req_o, hi_o, lo_o);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("mid_rst_hi", hi_o, 32'd0);
    check("mid_rst_lo", lo_o, 32'd0);
    hilo_rd_i = 1'b0;
    issue(MDU_DIVU, 32'd9, 32'd3);
    wait_idle(n);
    report("DIVU 9/3", n);
    check("post_rst_cycles", 32'(n), 32'd33);
    check("post_rst_lo", lo_o, 32'd3);
    check("post_rst_hi", hi_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
